// File: rtl/button_event_decoder.sv
// Classifies debounced button gestures into single/double/long events.
// Optional event counter enabled by defining BUTTON_EVENT_COUNT_EN.
module button_event_decoder #(
  parameter int LONG_CYCLES = 1000,
  parameter int GAP_CYCLES  = 400,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  output logic       single_o,
  output logic       double_o,
  output logic       long_o,
  output logic       hold_o,
  output logic       busy_o,
  output logic [7:0] event_cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    LONG_HOLD,
    WAIT2,
    PRESS2
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             btn_q;
  logic             rise, fall;
  logic             single_d, double_d, long_d;

  assign rise = btn & ~btn_q;
  assign fall = ~btn & btn_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      btn_q    <= 1'b0;
      single_o <= 1'b0;
      double_o <= 1'b0;
      long_o   <= 1'b0;
      hold_o   <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      btn_q    <= btn;
      single_o <= single_d;
      double_o <= double_d;
      long_o   <= long_d;
      hold_o   <= (state_d == LONG_HOLD);
      busy_o   <= (state_d != IDLE);
    end
  end

  // Fall beats the long timeout, rise beats the gap timeout.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (rise) state_d = PRESS1;
      end
      PRESS1: begin
        if (fall) state_d = WAIT2;
        else if (cnt == LONG_LAST) state_d = LONG_HOLD;
      end
      LONG_HOLD: begin
        if (fall) state_d = IDLE;
      end
      WAIT2: begin
        if (rise) state_d = PRESS2;
        else if (cnt == GAP_LAST) state_d = IDLE;
      end
      PRESS2: begin
        if (fall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter restarts on every state entry; it only runs while timing.
  always_comb begin
    cnt_d    = cnt;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    if (state_d != state) begin
      cnt_d = '0;
    end else if (state == PRESS1 || state == WAIT2) begin
      cnt_d = cnt + CNT_W'(1);
    end
    unique case (1'b1)
      (state == PRESS1): long_d = ~fall & (cnt == LONG_LAST);
      (state == WAIT2):  single_d = ~rise & (cnt == GAP_LAST);
      (state == PRESS2): double_d = fall;
      default: ;
    endcase
  end

`ifdef BUTTON_EVENT_COUNT_EN
  logic [7:0] ev_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ev_cnt <= '0;
    end else if (single_o | double_o | long_o) begin
      ev_cnt <= ev_cnt + 8'd1;
    end
  end

  assign event_cnt_o = ev_cnt;
`else
  assign event_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: timestamp-based gesture model,
// directed boundary cases and randomized gestures.
module tb_button_event_decoder;

  localparam int LONG = 20;
  localparam int GAP  = 10;

  logic       clk;
  logic       rst_n;
  logic       btn;
  logic       single_o, double_o, long_o, hold_o, busy_o;
  logic [7:0] event_cnt_o;

  button_event_decoder #(
    .LONG_CYCLES(LONG),
    .GAP_CYCLES (GAP),
    .CNT_W      (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn),
    .single_o   (single_o),
    .double_o   (double_o),
    .long_o     (long_o),
    .hold_o     (hold_o),
    .busy_o     (busy_o),
    .event_cnt_o(event_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Gesture model: timestamps of the rise/fall edges and plain flags.
  int now = 0;
  bit m_prev, r, f;
  bit active, released, second, is_long;
  int t_rise, t_fall;
  bit p_s, p_d, p_l;
  int evcnt;

  always @(posedge clk) begin
    now++;
    if (!rst_n) begin
      m_prev = 0; active = 0; released = 0;
      second = 0; is_long = 0;
      p_s = 0; p_d = 0; p_l = 0; evcnt = 0;
    end else begin
      r = btn && !m_prev;
      f = !btn && m_prev;
      m_prev = btn;
      if (p_s || p_d || p_l) evcnt = (evcnt + 1) % 256;
      p_s = 0; p_d = 0; p_l = 0;
      if (!active) begin
        if (r) begin
          active = 1; released = 0; second = 0;
          is_long = 0; t_rise = now;
        end
      end else if (is_long) begin
        if (f) begin active = 0; is_long = 0; end
      end else if (second) begin
        if (f) begin p_d = 1; active = 0; end
      end else if (released) begin
        if (r) second = 1;
        else if (now - t_fall == GAP) begin
          p_s = 1; active = 0;
        end
      end else begin
        if (f) begin released = 1; t_fall = now; end
        else if (now - t_rise == LONG) begin
          p_l = 1; is_long = 1;
        end
      end
    end
  end

  int dut_ns = 0, dut_nd = 0, dut_nl = 0;
  int dut_s_at = 0, dut_d_at = 0, dut_l_at = 0;
  int exp_ev;

  always @(negedge clk) begin
    if (now > 0) begin
`ifdef BUTTON_EVENT_COUNT_EN
      exp_ev = evcnt;
`else
      exp_ev = 0;
`endif
      chk("single", int'(single_o), int'(p_s));
      chk("double", int'(double_o), int'(p_d));
      chk("long",   int'(long_o),   int'(p_l));
      chk("hold",   int'(hold_o),   int'(active && is_long));
      chk("busy",   int'(busy_o),   int'(active));
      chk("evcnt",  int'(event_cnt_o), exp_ev);
      if (single_o) begin dut_ns++; dut_s_at = now; end
      if (double_o) begin dut_nd++; dut_d_at = now; end
      if (long_o)   begin dut_nl++; dut_l_at = now; end
    end
  end

  task automatic hold(bit v, int n);
    btn = v;
    repeat (n) @(negedge clk);
  endtask

  int s0, d0, l0, fe, re;

  initial begin
    rst_n = 1'b0;
    btn   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      btn = ~btn;
    end
    @(negedge clk);
    rst_n = 1'b1;
    hold(0, 5);
    chk("rst_quiet", dut_ns + dut_nd + dut_nl, 0);
    chk("rst_busy", int'(busy_o), 0);

    // single click
    s0 = dut_ns; d0 = dut_nd; l0 = dut_nl;
    hold(1, 5);
    fe = now + 1;
    hold(0, 20);
    chk("single_cnt", dut_ns - s0, 1);
    chk("single_lat", dut_s_at - fe, GAP);
    chk("single_other", (dut_nd - d0) + (dut_nl - l0), 0);

    // double click
    s0 = dut_ns; d0 = dut_nd;
    hold(1, 5); hold(0, 4); hold(1, 5);
    fe = now + 1;
    hold(0, 20);
    chk("double_cnt", dut_nd - d0, 1);
    chk("double_lat", dut_d_at - fe, 0);
    chk("double_nosingle", dut_ns - s0, 0);

    // long press
    s0 = dut_ns; l0 = dut_nl;
    re = now + 1;
    hold(1, 30);
    chk("long_cnt", dut_nl - l0, 1);
    chk("long_lat", dut_l_at - re, LONG);
    chk("hold_lit", int'(hold_o), 1);
    hold(0, 20);
    chk("long_nosingle", dut_ns - s0, 0);
    chk("long_busy", int'(busy_o), 0);

    // fall on the long-timeout edge stays short
    s0 = dut_ns; l0 = dut_nl;
    hold(1, LONG); hold(0, 20);
    chk("bnd_fall_long", dut_nl - l0, 0);
    chk("bnd_fall_single", dut_ns - s0, 1);
    l0 = dut_nl;
    hold(1, LONG + 1); hold(0, 20);
    chk("bnd_long_plus1", dut_nl - l0, 1);

    // rise on the gap-timeout edge is a double
    s0 = dut_ns; d0 = dut_nd;
    hold(1, 5); hold(0, GAP); hold(1, 3); hold(0, 20);
    chk("bnd_rise_double", dut_nd - d0, 1);
    chk("bnd_rise_single", dut_ns - s0, 0);
    s0 = dut_ns; d0 = dut_nd;
    hold(1, 5); hold(0, GAP + 1); hold(1, 3); hold(0, 20);
    chk("bnd_gap_plus1_s", dut_ns - s0, 2);
    chk("bnd_gap_plus1_d", dut_nd - d0, 0);

    // reset while waiting for a second press
    s0 = dut_ns;
    hold(1, 5); hold(0, 3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hold(0, 20);
    chk("rst_wait2_single", dut_ns - s0, 0);
    chk("rst_wait2_busy", int'(busy_o), 0);

    // randomized gestures
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      hold(1, $urandom_range(1, 25));
      hold(0, $urandom_range(1, 14));
    end
    hold(0, 20);

    // event counter wrap
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (255) begin
      hold(1, 2); hold(0, 12);
    end
`ifdef BUTTON_EVENT_COUNT_EN
    chk("ev_255", int'(event_cnt_o), 255);
`else
    chk("ev_255", int'(event_cnt_o), 0);
`endif
    hold(1, 2); hold(0, 12);
    chk("ev_wrap", int'(event_cnt_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Sits directly downstream of the button debouncer.
- Consumes the debounced, clk-synchronous button level and classifies each gesture as a single click, a double click or a long press.
- Emits one-cycle event pulses plus hold/busy status for LED and control logic.
- Purely sequential: an edge detector, one cycle counter and a 5-state FSM.

Parameters:
- LONG_CYCLES, 1000, press duration (clk cycles) at which a press becomes a long press; legal range 2 to 2^CNT_W-1.
- GAP_CYCLES, 400, max release-to-second-press interval for a double click; legal range 2 to 2^CNT_W-1.
- CNT_W, 16, width of the shared cycle counter.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  synchronous active-low reset.
- btn  input  1  debounced button level, synchronous to clk, 1 = pressed.
- single_o  output  1  one-cycle pulse: single click recognised.
- double_o  output  1  one-cycle pulse: double click recognised.
- long_o  output  1  one-cycle pulse: long press recognised.
- hold_o  output  1  high while a recognised long press is still held.
- busy_o  output  1  high whenever FSM is not IDLE.
- event_cnt_o  output  8  total recognised events (see Optional Feature).

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low. All state changes occur on posedge clk only.
- Reset (rst_n=0 at a posedge):
  - state=IDLE, cnt=0, btn_q=0.
  - All outputs 0, event_cnt_o=0.
  - Reset overrides any in-flight gesture; no pulse is emitted for it.
- Edge detect:
  - btn_q<=btn every cycle.
  - rise = btn & ~btn_q; fall = ~btn & btn_q, both evaluated at the same edge.
  - btn held high through reset release counts as a rise on the first post-reset edge.
- FSM (transitions at the edge where the condition is sampled):
  - IDLE: rise -> PRESS1, cnt<=0.
  - PRESS1:
    - fall -> WAIT2, cnt<=0.
    - else if cnt==LONG_CYCLES-1 -> LONG_HOLD, fire long_o.
    - else cnt<=cnt+1.
  - LONG_HOLD: hold_o=1. fall -> IDLE. Release emits no other event.
  - WAIT2:
    - rise -> PRESS2.
    - else if cnt==GAP_CYCLES-1 -> IDLE, fire single_o.
    - else cnt<=cnt+1.
  - PRESS2: fall -> IDLE, fire double_o. No long-press timing in PRESS2; an arbitrarily long second press still yields double_o.
- Outputs:
  - Pulses are registered: high for exactly one cycle, starting the cycle after the deciding edge.
  - At most one of single_o/double_o/long_o is high in any cycle.
  - hold_o and busy_o are registered from next-state.
- Latency (all in edges, counted from the relevant detection edge):
  - long_o: press held continuously; decided at the LONG_CYCLES-th edge after rise detection.
  - single_o: decided at the GAP_CYCLES-th edge after fall detection.
  - double_o: decided at the second fall detection edge.
- Simultaneous events:
  - PRESS1, fall and cnt==LONG_CYCLES-1 on the same edge: fall wins (short press).
  - WAIT2, rise and cnt==GAP_CYCLES-1 on the same edge: rise wins (double-click path).
- Counter:
  - Unsigned CNT_W bits. Never exceeds the active limit-1, so it cannot wrap.
  - Cleared on every state entry.

Optional Feature:
- Macro: BUTTON_EVENT_COUNT_EN.
- Defined:
  - event_cnt_o increments by 1 on each cycle where single_o, double_o or long_o is high.
  - Wraps 255 -> 0. Reset to 0.
- Undefined:
  - event_cnt_o tied to 8'd0 and the counter register is not instantiated.
  - All other behaviour is identical.

Test Plan (LONG_CYCLES=20, GAP_CYCLES=10, CNT_W=8):
- Reset: rst_n=0 for 3 cycles while btn toggles -> all outputs 0, busy_o=0, event_cnt_o=0; no pulse after rst_n=1 with btn=0.
- Single click: btn high 5 cycles, then low 20 cycles -> single_o high exactly one cycle, after the 10th edge following fall detection; double_o=long_o=0.
- Double click: btn high 5, low 4, high 5, low -> double_o one cycle after second fall detection; single_o never asserts.
- Long press: btn high 30 cycles -> long_o one cycle after 20th edge; hold_o high from then until fall detection; no single_o afterwards; busy_o=0 after release.
- Boundaries:
  - Fall detected exactly at the edge where cnt==19 -> short press path (no long_o).
  - Second rise detected at the edge where cnt==9 in WAIT2 -> double_o, no single_o.
- Reset mid-gesture and counter wrap:
  - rst_n=0 during WAIT2 -> no single_o, state IDLE.
  - With BUTTON_EVENT_COUNT_EN: 256 single clicks -> event_cnt_o returns to 0.
  - Without the macro: event_cnt_o stays 0 throughout.
